// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports and two byte-strobed write ports.
// Also provides optional same-cycle write bypass, an optional hardwired-zero r0 and a per-register busy scoreboard.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32'sd32,
    parameter int ADDR_WIDTH = 32'sd5,
    parameter int BYPASS     = 32'sd1,
    parameter int ZERO_REG   = 32'sd1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     raddr1,
    input  logic [ADDR_WIDTH-1:0]     raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2,
    output logic                      busy1,
    output logic                      busy2,
    input  logic                      wen_a,
    input  logic [ADDR_WIDTH-1:0]     waddr_a,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_a,
    input  logic [DATA_WIDTH-1:0]     wdata_a,
    input  logic                      wen_b,
    input  logic [ADDR_WIDTH-1:0]     waddr_b,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_b,
    input  logic [DATA_WIDTH-1:0]     wdata_b,
    input  logic                      mark_en,
    input  logic [ADDR_WIDTH-1:0]     mark_addr
);
    localparam int NUM_REGS  = 32'sd1 << ADDR_WIDTH;
    localparam int BYTE_W    = 32'sd8;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
    localparam bit BYPASS_EN = (BYPASS != 32'sd0);
    localparam bit ZERO_EN   = (ZERO_REG != 32'sd0);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_r;
    logic [NUM_REGS-1:0]   busy_next_s;
    logic [DATA_WIDTH-1:0] byp1_s;
    logic [DATA_WIDTH-1:0] byp2_s;

    // Per-byte overlay of up to two writes onto a base word; port B has priority over port A.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] base,
        input logic                  hit_a,
        input logic [NUM_BYTES-1:0]  strb_a,
        input logic [DATA_WIDTH-1:0] data_a,
        input logic                  hit_b,
        input logic [NUM_BYTES-1:0]  strb_b,
        input logic [DATA_WIDTH-1:0] data_b
    );
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int b = 32'sd0; b < NUM_BYTES; b++) begin
            res[b*BYTE_W +: BYTE_W] = (hit_b && strb_b[b]) ? data_b[b*BYTE_W +: BYTE_W] :
                                      (hit_a && strb_a[b]) ? data_a[b*BYTE_W +: BYTE_W] :
                                                             base[b*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    // Scoreboard next state: writes clear, a mark on the same register overrides the clear.
    always_comb begin
        busy_next_s = '0;
        for (int i = 32'sd0; i < NUM_REGS; i++) begin
            busy_next_s[i] = (ZERO_EN && (i == 32'sd0)) ? 1'b0 :
                ((mark_en && (mark_addr == ADDR_WIDTH'(i))) ||
                 (busy_r[i] && !(wen_a && (waddr_a == ADDR_WIDTH'(i)))
                            && !(wen_b && (waddr_b == ADDR_WIDTH'(i)))));
        end
    end

    // Register array and scoreboard state; reset overrides all writes and marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 32'sd0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
            busy_r <= '0;
        end else begin
            for (int i = 32'sd0; i < NUM_REGS; i++) begin
                regs_r[i] <= (ZERO_EN && (i == 32'sd0)) ? '0 :
                    merge_bytes(regs_r[i],
                                wen_a && (waddr_a == ADDR_WIDTH'(i)), wstrb_a, wdata_a,
                                wen_b && (waddr_b == ADDR_WIDTH'(i)), wstrb_b, wdata_b);
            end
            busy_r <= busy_next_s;
        end
    end

    // Bypass candidates: stored word overlaid with this cycle's writes to the same address.
    assign byp1_s = merge_bytes(regs_r[raddr1],
                                wen_a && (waddr_a == raddr1), wstrb_a, wdata_a,
                                wen_b && (waddr_b == raddr1), wstrb_b, wdata_b);
    assign byp2_s = merge_bytes(regs_r[raddr2],
                                wen_a && (waddr_a == raddr2), wstrb_a, wdata_a,
                                wen_b && (waddr_b == raddr2), wstrb_b, wdata_b);

    assign rdata1 = (ZERO_EN && (raddr1 == '0)) ? '0 : (BYPASS_EN ? byp1_s : regs_r[raddr1]);
    assign rdata2 = (ZERO_EN && (raddr2 == '0)) ? '0 : (BYPASS_EN ? byp2_s : regs_r[raddr2]);
    assign busy1  = busy_r[raddr1];
    assign busy2  = busy_r[raddr2];
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: two configurations (bypass+zero-reg, plain) share all inputs
// and are compared every cycle against an array model, plus hand-computed literal checks.
module tb_reg_file_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  raddr1 = 5'd0, raddr2 = 5'd0;
    logic        wen_a = 1'b0, wen_b = 1'b0, mark_en = 1'b0;
    logic [4:0]  waddr_a = 5'd0, waddr_b = 5'd0, mark_addr = 5'd0;
    logic [3:0]  wstrb_a = 4'h0, wstrb_b = 4'h0;
    logic [31:0] wdata_a = 32'h0, wdata_b = 32'h0;

    logic [31:0] rd1_z, rd2_z, rd1_p, rd2_p;
    logic        bz1, bz2, bp1, bp2;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    // index 1: BYPASS=1/ZERO_REG=1 instance, index 0: BYPASS=0/ZERO_REG=0 instance
    logic [31:0] m_mem  [2][32];
    logic [31:0] nx_mem [2][32];
    logic [31:0] m_busy [2];
    logic [31:0] nx_busy [2];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_z), .rdata2(rd2_z),
        .busy1(bz1), .busy2(bz2), .wen_a(wen_a), .waddr_a(waddr_a), .wstrb_a(wstrb_a), .wdata_a(wdata_a),
        .wen_b(wen_b), .waddr_b(waddr_b), .wstrb_b(wstrb_b), .wdata_b(wdata_b),
        .mark_en(mark_en), .mark_addr(mark_addr));

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(0)) dut_p (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_p), .rdata2(rd2_p),
        .busy1(bp1), .busy2(bp2), .wen_a(wen_a), .waddr_a(waddr_a), .wstrb_a(wstrb_a), .wdata_a(wdata_a),
        .wen_b(wen_b), .waddr_b(waddr_b), .wstrb_b(wstrb_b), .wdata_b(wdata_b),
        .mark_en(mark_en), .mark_addr(mark_addr));

    function automatic logic [31:0] put(input logic [31:0] old, input logic [3:0] strb, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Model next state: apply write A, then write B (so B wins), then marks win over clears.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            nx_busy[c] = m_busy[c];
            if (wen_a) nx_busy[c][waddr_a] = 1'b0;
            if (wen_b) nx_busy[c][waddr_b] = 1'b0;
            if (mark_en) nx_busy[c][mark_addr] = 1'b1;
            if (c == 1) nx_busy[c][0] = 1'b0;
            for (int r = 0; r < 32; r++) begin
                nx_mem[c][r] = m_mem[c][r];
                if (wen_a && waddr_a == 5'(r)) nx_mem[c][r] = put(nx_mem[c][r], wstrb_a, wdata_a);
                if (wen_b && waddr_b == 5'(r)) nx_mem[c][r] = put(nx_mem[c][r], wstrb_b, wdata_b);
                if (c == 1 && r == 0) nx_mem[c][r] = 32'h0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_busy[c] <= 32'h0;
                for (int r = 0; r < 32; r++) m_mem[c][r] <= 32'h0;
            end
        end else begin
            m_mem  <= nx_mem;
            m_busy <= nx_busy;
        end
    end

    // Expected combinational read: bypass config overlays strobed bytes of this cycle's writes.
    function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
        logic [31:0] v;
        v = m_mem[c][a];
        if (c == 1) begin
            if (a == 5'd0) return 32'h0;
            if (wen_a && waddr_a == a) v = put(v, wstrb_a, wdata_a);
            if (wen_b && waddr_b == a) v = put(v, wstrb_b, wdata_b);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("z_rdata1", rd1_z, exp_rd(1, raddr1));
            chk("z_rdata2", rd2_z, exp_rd(1, raddr2));
            chk("z_busy1", {31'b0, bz1}, {31'b0, m_busy[1][raddr1]});
            chk("z_busy2", {31'b0, bz2}, {31'b0, m_busy[1][raddr2]});
            chk("p_rdata1", rd1_p, exp_rd(0, raddr1));
            chk("p_rdata2", rd2_p, exp_rd(0, raddr2));
            chk("p_busy1", {31'b0, bp1}, {31'b0, m_busy[0][raddr1]});
            chk("p_busy2", {31'b0, bp2}, {31'b0, m_busy[0][raddr2]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen_a = 1'b0; wen_b = 1'b0; mark_en = 1'b0;
        wstrb_a = 4'h0; wstrb_b = 4'h0;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen_a = 1'b1; waddr_a = a; wstrb_a = s; wdata_a = d;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen_b = 1'b1; waddr_b = a; wstrb_b = s; wdata_b = d;
    endtask

    initial begin
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        // every address on both ports reads zero and not busy after reset
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk("rst_rd1", rd1_z, 32'h0); chk("rst_rd2", rd2_p, 32'h0);
            chk("rst_busy", {30'b0, bz1, bp2}, 32'h0);
        end
        step();

        // byte strobes
        wr_a(5'd5, 4'hF, 32'hAABBCCDD); step();
        wr_a(5'd5, 4'h5, 32'h11223344); step();
        idle(); raddr1 = 5'd5; #1;
        chk("strb_z", rd1_z, 32'hAA22CC44); chk("strb_p", rd1_p, 32'hAA22CC44);

        // dual-port same-address merge, then different addresses
        wr_a(5'd7, 4'hF, 32'h11111111); wr_b(5'd7, 4'h3, 32'h22222222); step();
        idle(); raddr1 = 5'd7; #1;
        chk("merge_z", rd1_z, 32'h11112222); chk("merge_p", rd1_p, 32'h11112222);
        wr_a(5'd3, 4'hF, 32'h33333333); wr_b(5'd4, 4'hF, 32'h44444444); step();
        idle(); raddr1 = 5'd3; raddr2 = 5'd4; #1;
        chk("dual_r3", rd1_z, 32'h33333333); chk("dual_r4", rd2_p, 32'h44444444);

        // bypass full word, then partial-byte bypass with both ports
        raddr1 = 5'd9; wr_a(5'd9, 4'hF, 32'hDEADBEEF); #1;
        chk("byp_z", rd1_z, 32'hDEADBEEF); chk("nobyp_old", rd1_p, 32'h0);
        step(); idle(); #1;
        chk("nobyp_new", rd1_p, 32'hDEADBEEF);
        raddr2 = 5'd9; wr_a(5'd9, 4'h9, 32'hAAAAAAAA); wr_b(5'd9, 4'h8, 32'h12345678); #1;
        chk("byp_part_z", rd2_z, 32'h12ADBEAA); chk("byp_part_p", rd2_p, 32'hDEADBEEF);
        step(); idle(); #1;
        chk("part_store_p", rd2_p, 32'h12ADBEAA);

        // scoreboard: mark, clear by zero-strobe write, mark+clear same cycle
        raddr1 = 5'd12; mark_en = 1'b1; mark_addr = 5'd12; #1;
        chk("mark_pre", {31'b0, bz1}, 32'h0);
        step(); idle(); #1;
        chk("mark_z", {31'b0, bz1}, 32'h1); chk("mark_p", {31'b0, bp1}, 32'h1);
        wr_a(5'd12, 4'h0, 32'hFFFFFFFF); #1;
        chk("clr_pre", {31'b0, bz1}, 32'h1);
        step(); idle(); #1;
        chk("clr_z", {31'b0, bz1}, 32'h0); chk("zstrb_data", rd1_z, 32'h0);
        mark_en = 1'b1; mark_addr = 5'd12; wr_b(5'd12, 4'hF, 32'h0000ABCD); step();
        idle(); #1;
        chk("markwin_z", {31'b0, bz1}, 32'h1); chk("markwin_p", {31'b0, bp1}, 32'h1);

        // zero register versus ordinary r0
        raddr1 = 5'd0; wr_a(5'd0, 4'hF, 32'hFFFFFFFF); mark_en = 1'b1; mark_addr = 5'd0; #1;
        chk("r0_byp_z", rd1_z, 32'h0);
        step(); idle(); #1;
        chk("r0_z", rd1_z, 32'h0); chk("r0_busy_z", {31'b0, bz1}, 32'h0);
        chk("r0_p", rd1_p, 32'hFFFFFFFF); chk("r0_busy_p", {31'b0, bp1}, 32'h1);

        // reset overrides a write and a mark in the same cycle
        rst = 1'b1; wr_a(5'd2, 4'hF, 32'h00000005); mark_en = 1'b1; mark_addr = 5'd3; step();
        rst = 1'b0; idle(); raddr1 = 5'd2; raddr2 = 5'd3; #1;
        chk("rstpri_z", rd1_z, 32'h0); chk("rstpri_p", rd1_p, 32'h0);
        chk("rstpri_busy", {30'b0, bz2, bp2}, 32'h0);

        // deterministic mixed traffic checked by the model every cycle
        for (int i = 0; i < 48; i++) begin
            wen_a = (i % 3) != 0; waddr_a = 5'(i * 7); wstrb_a = 4'(i);
            wdata_a = 32'(i) * 32'h01030507;
            wen_b = (i % 4) != 1; waddr_b = 5'(i * 3); wstrb_b = 4'(i >> 1) ^ 4'hA;
            wdata_b = ~wdata_a ^ 32'(i);
            mark_en = (i % 5) < 3; mark_addr = 5'(i * 5);
            raddr1 = (i % 2 == 0) ? waddr_a : 5'(i * 11);
            raddr2 = (i % 3 == 0) ? mark_addr : waddr_b;
            step();
        end
        idle();
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
